// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffnq_pkg.sv
// Shared constants, types and helpers for the falling-edge register pipeline.
// Optional parity chain is enabled by GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN.
package gf180mcu_fd_sc_mcu7t5v0__dffnq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 2;

    // Width of the occupancy count: must hold every value 0..depth inclusive.
    function automatic int unsigned fill_w(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Image of one stage at the default width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 vld;
        logic                 par;
    } stage_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffnq_stage.sv
// One falling-edge pipeline stage: data, valid and (optionally) parity bit.
// The parity flop exists only when PAR_EN is set by the top, which keys it off GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN.
module gf180mcu_fd_sc_mcu7t5v0__dffnq_stage
    import gf180mcu_fd_sc_mcu7t5v0__dffnq_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               PAR_EN    = 1'b0
) (
    input  logic             clkn,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             vld_in,
    input  logic             par_in,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             par_out
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d,  vld_q;

    // Flush clears only the valid bit; data keeps its last value.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (en) begin
            data_d = data_in;
            vld_d  = vld_in;
        end
    end

    always_ff @(negedge clkn) begin
        if (rst) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_out = data_q;
    assign vld_out  = vld_q;

    if (PAR_EN) begin : g_par
        logic par_d, par_q;

        always_comb begin
            par_d = par_q;
            if (!flush && en) begin
                par_d = par_in;
            end
        end

        always_ff @(negedge clkn) begin
            if (rst) begin
                par_q <= ^RESET_VAL;
            end else begin
                par_q <= par_d;
            end
        end

        assign par_out = par_q;
    end else begin : g_nopar
        logic unused_par;
        assign unused_par = par_in;
        assign par_out    = 1'b0;
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe.sv
// WIDTH-bit, DEPTH-stage falling-edge register pipeline with valid tracking, flush and occupancy count.
// Define GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN to add the DP input, parity chain and PERR output.
module gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe
    import gf180mcu_fd_sc_mcu7t5v0__dffnq_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     CLKN,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     FLUSH,
    input  logic [WIDTH-1:0]         D,
    input  logic                     DV,
`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
    input  logic                     DP,
`endif
    output logic [WIDTH-1:0]         Q,
    output logic                     QV,
    output logic [fill_w(DEPTH)-1:0] FILL
`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
    ,
    output logic                     PERR
`endif
);

    localparam int unsigned FW = fill_w(DEPTH);

`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic dp_w;
    assign dp_w = DP;
`else
    localparam bit PAR_EN = 1'b0;
    logic dp_w;
    assign dp_w = 1'b0;
`endif

    logic [WIDTH-1:0] data_s [DEPTH];
    logic             vld_s  [DEPTH];
    logic             par_s  [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        logic             p_in;

        if (g == 0) begin : g_head
            assign d_in = D;
            assign v_in = DV;
            assign p_in = dp_w;
        end else begin : g_body
            assign d_in = data_s[g-1];
            assign v_in = vld_s[g-1];
            assign p_in = par_s[g-1];
        end

        gf180mcu_fd_sc_mcu7t5v0__dffnq_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .PAR_EN    (PAR_EN)
        ) u_stage (
            .clkn     (CLKN),
            .rst      (RST),
            .flush    (FLUSH),
            .en       (EN),
            .data_in  (d_in),
            .vld_in   (v_in),
            .par_in   (p_in),
            .data_out (data_s[g]),
            .vld_out  (vld_s[g]),
            .par_out  (par_s[g])
        );
    end

    logic [FW-1:0] fill_d, fill_q;

    // Entry and exit on the same shift cancel; wrap of the intermediate sum is harmless.
    always_comb begin
        fill_d = fill_q;
        if (FLUSH) begin
            fill_d = '0;
        end else if (EN) begin
            fill_d = fill_q + FW'(DV) - FW'(vld_s[DEPTH-1]);
        end
    end

    always_ff @(negedge CLKN) begin
        if (RST) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign Q    = data_s[DEPTH-1];
    assign QV   = vld_s[DEPTH-1];
    assign FILL = fill_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
    assign PERR = vld_s[DEPTH-1] & ((^data_s[DEPTH-1]) ^ par_s[DEPTH-1]);
`else
    logic unused_par_tail;
    assign unused_par_tail = par_s[DEPTH-1];
`endif

    logic [FW-1:0] vld_cnt;

    always_comb begin
        vld_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            vld_cnt = vld_cnt + FW'(vld_s[i]);
        end
    end

    fill_tracks_vld: assert property (@(negedge CLKN) disable iff (RST) fill_q == vld_cnt);
    fill_bounded:    assert property (@(negedge CLKN) disable iff (RST) fill_q <= FW'(DEPTH));

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe.sv
// Scoreboard bench for the falling-edge register pipeline (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
module tb_gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 3;
    localparam logic [7:0] RESET_VAL = 8'hA5;

    logic       CLKN  = 1'b1;
    logic       RST   = 1'b1;
    logic       EN    = 1'b0;
    logic       FLUSH = 1'b0;
    logic       DV    = 1'b0;
    logic       DP    = 1'b0;
    logic [7:0] D     = '0;
    logic [7:0] Q;
    logic       QV;
    logic [1:0] FILL;
`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
    logic       PERR;
`endif

    always #5 CLKN = ~CLKN;

    gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .CLKN  (CLKN),
        .RST   (RST),
        .EN    (EN),
        .FLUSH (FLUSH),
        .D     (D),
        .DV    (DV),
`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
        .DP    (DP),
`endif
        .Q     (Q),
        .QV    (QV),
        .FILL  (FILL)
`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
        ,
        .PERR  (PERR)
`endif
    );

    // Reference: the words written on the last DEPTH shifting edges since reset.
    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       p;
    } ent_t;

    ent_t       hist[$];
    logic [7:0] sbq[$];
    bit         shift_edge;
    int         nchecks = 0;
    int         nerr    = 0;
    logic [7:0] sb_w;

    function automatic logic [7:0] exp_q();
        if (hist.size() >= DEPTH) return hist[hist.size() - DEPTH].d;
        return RESET_VAL;
    endfunction

    function automatic logic exp_qv();
        if (hist.size() >= DEPTH) return hist[hist.size() - DEPTH].v;
        return 1'b0;
    endfunction

    function automatic int exp_fill();
        int cnt = 0;
        foreach (hist[i]) if (hist[i].v) cnt++;
        return cnt;
    endfunction

    function automatic logic exp_perr();
        ent_t e;
        if (hist.size() < DEPTH) return 1'b0;
        e = hist[hist.size() - DEPTH];
        return e.v & ((^e.d) ^ e.p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLKN) begin
        int inflight;
        shift_edge = 1'b0;
        if (RST) begin
            hist.delete();
            sbq.delete();
        end else if (FLUSH) begin
            inflight = exp_fill() - int'(exp_qv());
            repeat (inflight) void'(sbq.pop_back());
            foreach (hist[i]) hist[i].v = 1'b0;
        end else if (EN) begin
            hist.push_back('{d: D, v: DV, p: DP});
            if (DV) sbq.push_back(D);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            shift_edge = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge CLKN);
            #1;
            check("q",    32'(Q),    32'(exp_q()));
            check("qv",   32'(QV),   32'(exp_qv()));
            check("fill", 32'(FILL), 32'(exp_fill()));
`ifdef GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN
            check("perr", 32'(PERR), 32'(exp_perr()));
`endif
            if (shift_edge && QV) begin
                check("sb_level", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    sb_w = sbq.pop_front();
                    check("sb_data", 32'(Q), 32'(sb_w));
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic flush, input logic en,
                       input logic dv, input logic [7:0] d, input logic dp);
        @(posedge CLKN);
        RST   = rst;
        FLUSH = flush;
        EN    = en;
        DV    = dv;
        D     = d;
        DP    = dp;
    endtask

    initial begin
        logic [7:0] rd;
        int         r;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 1; i <= 4; i++) begin
            rd = 8'(i);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, rd, ^rd);
        end

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, ^8'h11);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h22, ^8'h22);
        for (int i = 0; i < 5; i++) begin
            rd = 8'($urandom);
            cyc(1'b0, 1'b0, 1'b0, 1'($urandom), rd, ^rd);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0);

        for (int i = 0; i < 3; i++) begin
            rd = 8'h40 + 8'(i);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, rd, ^rd);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h51, ^8'h51);

        for (int i = 0; i < 3; i++) begin
            rd = 8'h60 + 8'(i);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, rd, ^rd);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h70, ^8'h70);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd = 8'h80 + 8'(i);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, rd, ^rd);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h90, 1'b0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            rd = 8'($urandom);
            cyc(r < 2, (r >= 2) && (r < 6), $urandom_range(0, 3) != 0,
                1'($urandom), rd, (^rd) ^ ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        @(negedge CLKN);
        #2;
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe.md
# gf180mcu_fd_sc_mcu7t5v0__dffnq_pipe

Parametrised falling-edge register pipeline for the 7-track 5V0 library: WIDTH-bit data delayed through DEPTH negative-edge stages, with per-stage valid tracking, clock enable, flush and an occupancy counter. Sits wherever a single-bit falling-edge flop is too narrow or too shallow, e.g. half-cycle retiming of buses between posedge domains and pad-side capture paths.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 2, number of stages (≥1); DEPTH=1 is a single enabled register
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset
- CLKN  input  1  clock; all state updates on the falling edge
- RST  input  1  reset, synchronous, active-high, sampled on the falling edge of CLKN
- EN  input  1  shift enable
- FLUSH  input  1  invalidate all stages
- D  input  WIDTH  data in
- DV  input  1  D is valid
- DP  input  1  even-parity bit for D (only with PARITY_EN)
- Q  output  WIDTH  data of last stage
- QV  output  1  valid of last stage
- FILL  output  $clog2(DEPTH+1)  number of valid stages
- PERR  output  1  parity error on last stage (only with PARITY_EN)

## Operation
- State: data[0..DEPTH-1], vld[0..DEPTH-1], fill counter; with PARITY_EN also par[0..DEPTH-1].
- Priority per falling edge: RST > FLUSH > EN > hold.
- RST: data[i]=RESET_VAL, vld[i]=0, par[i]=^RESET_VAL, FILL=0.
- FLUSH (RST low): vld[i]=0, FILL=0; data and par unchanged; EN ignored that edge.
- EN (RST, FLUSH low): data[0]=D, vld[0]=DV, par[0]=DP; stage i takes stage i-1 for i≥1.
- EN low: all state holds, including FILL.
- FILL on shift: FILL + DV − vld[DEPTH-1] (pre-edge value); simultaneous entry and exit leaves FILL unchanged. FILL never exceeds DEPTH and never underflows; FILL always equals popcount(vld).
- Q=data[DEPTH-1], QV=vld[DEPTH-1], directly from flops, no combinational path from inputs.
- PERR = QV & (^Q ^ par[DEPTH-1]); combinational from flops only; 0 when QV=0.
- Invalid data still shifts through (bubbles carry data); consumers qualify with QV.

## Timing
- Latency: D/DV sampled at enabled falling edge k appear on Q/QV after enabled edge k+DEPTH-1; stalled edges (EN=0) add no cycles beyond the stall.
- Full throughput: one word per enabled edge, no back-pressure.
- Outputs after reset edge: Q=RESET_VAL, QV=0, FILL=0, PERR=0.
- RST asserted mid-stream discards all content on that edge; first word written after release reaches Q after DEPTH enabled edges.
- RST/FLUSH take effect regardless of EN.
- Rising edge of CLKN has no effect.

## Configuration
- GF180MCU_FD_SC_MCU7T5V0_DFFNQ_PIPE_PARITY_EN defined: DP input, par[] chain and PERR output present.
- Undefined: DP and PERR ports absent; no parity flops; all other behaviour identical.

## Structure
- Package gf180mcu_fd_sc_mcu7t5v0__dffnq_pkg: default WIDTH/DEPTH constants, fill-width function ($clog2(DEPTH+1)), stage struct typedef (data, vld, par).
- Sub-module gf180mcu_fd_sc_mcu7t5v0__dffnq_stage: one WIDTH+2-bit falling-edge stage with sync reset, flush and enable; top generates DEPTH instances plus the FILL counter and PERR logic.

## Test plan
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5, RST high one falling edge -> Q=8'hA5, QV=0, FILL=0, PERR=0.
- Streaming: EN=1, DV=1, D=8'h01,8'h02,8'h03,8'h04 on successive edges -> Q=8'h01 with QV=1 after third edge, then 8'h02, 8'h03; FILL 1,2,3,3.
- Stall: after loading 8'h11,8'h22, EN=0 for 5 edges -> Q, QV, FILL=2 unchanged; resume EN=1 -> 8'h11 at Q after one more edge.
- Bubble/simultaneous: full pipe (FILL=3), shift DV=0 -> FILL=2; shift DV=1 while QV=1 -> FILL stays 2.
- Flush vs reset: full pipe, FLUSH=1 with EN=1 -> QV=0, FILL=0, Q keeps prior data; RST and FLUSH together -> Q=RESET_VAL.
- Parity (macro defined): D=8'h03, DP=1 (wrong) -> PERR=1 only while that word has QV=1; D=8'h07, DP=1 -> PERR=0.
